// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcode encoding and helpers shared by alu_seq and alu_core
package alu_seq_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOTA = 3'd0;
    localparam logic [OP_W-1:0] OP_NOTB = 3'd1;
    localparam logic [OP_W-1:0] OP_AND  = 3'd2;
    localparam logic [OP_W-1:0] OP_OR   = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
    localparam logic [OP_W-1:0] OP_ADD  = 3'd6;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd7;

    function automatic logic is_arith(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational eight-operation ALU producing result and c/n/z/v flags
module alu_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_v
);

    logic             is_sub;
    logic             arith;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;

    // Subtraction reuses the adder as a + ~b + 1, so flag_c reads as "no borrow".
    always_comb begin
        is_sub = (op == OP_SUB);
        arith  = is_arith(op);
        b_eff  = is_sub ? ~b : b;
        sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};

        result = '0;
        case (op)
            OP_NOTA: result = ~a;
            OP_NOTB: result = ~b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_XNOR: result = ~(a ^ b);
            OP_ADD,
            OP_SUB:  result = sum[WIDTH-1:0];
            default: result = '0;
        endcase

        flag_c = arith & sum[WIDTH];
        flag_v = arith & (a[WIDTH-1] == b_eff[WIDTH-1]) & (result[WIDTH-1] != a[WIDTH-1]);
        flag_n = result[WIDTH-1];
        flag_z = (result == '0);
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered valid/ready ALU with op counter; optional accumulator under ALU_SEQ_ACC_EN
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    input  logic             src_acc,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_v,
    output logic [CNT_W-1:0] op_cnt
);

    logic             in_fire;
    logic             out_fire;
    logic [WIDTH-1:0] core_a;
    logic [WIDTH-1:0] core_res;
    logic             core_c;
    logic             core_n;
    logic             core_z;
    logic             core_v;

    assign in_ready = !out_valid || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

`ifdef ALU_SEQ_ACC_EN
    logic [WIDTH-1:0] acc;

    // Operand A taps the pre-update accumulator so chained ops run every cycle.
    assign core_a = src_acc ? acc : a;

    always_ff @(posedge clk) begin
        if (reset || acc_clr) begin
            acc <= '0;
        end else if (in_fire) begin
            acc <= core_res;
        end
    end
`else
    logic unused_acc_ctrl;

    assign unused_acc_ctrl = src_acc ^ acc_clr;
    assign core_a          = a;
`endif

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (core_a),
        .b      (b),
        .op     (op),
        .result (core_res),
        .flag_c (core_c),
        .flag_n (core_n),
        .flag_z (core_z),
        .flag_v (core_v)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            flag_c    <= 1'b0;
            flag_n    <= 1'b0;
            flag_z    <= 1'b0;
            flag_v    <= 1'b0;
            op_cnt    <= '0;
        end else if (in_fire) begin
            out_valid <= 1'b1;
            result    <= core_res;
            flag_c    <= core_c;
            flag_n    <= core_n;
            flag_z    <= core_z;
            flag_v    <= core_v;
            op_cnt    <= op_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq against an arithmetic reference model
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = 6;
    localparam int CNT_MOD = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OP_W-1:0]  op;
    logic             src_acc;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_c;
    logic             flag_n;
    logic             flag_z;
    logic             flag_v;
    logic [CNT_W-1:0] op_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [2:0] o;
        logic [7:0] xa;
        logic [7:0] xb;
        logic [7:0] res;
        logic [3:0] cnzv;
    } vec_t;

    vec_t dir [11] = '{
        '{OP_ADD,  8'h7F, 8'h01, 8'h80, 4'b0101},
        '{OP_ADD,  8'hFF, 8'h01, 8'h00, 4'b1010},
        '{OP_SUB,  8'h05, 8'h05, 8'h00, 4'b1010},
        '{OP_SUB,  8'h00, 8'h01, 8'hFF, 4'b0100},
        '{OP_SUB,  8'h80, 8'h01, 8'h7F, 4'b1001},
        '{OP_AND,  8'hF0, 8'h3C, 8'h30, 4'b0000},
        '{OP_OR,   8'hF0, 8'h3C, 8'hFC, 4'b0100},
        '{OP_XOR,  8'hF0, 8'h3C, 8'hCC, 4'b0100},
        '{OP_XNOR, 8'hF0, 8'h3C, 8'h33, 4'b0000},
        '{OP_NOTA, 8'hF0, 8'h3C, 8'h0F, 4'b0000},
        '{OP_NOTB, 8'hF0, 8'h3C, 8'hC3, 4'b0100}
    };

    alu_seq #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .src_acc   (src_acc),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_c    (flag_c),
        .flag_n    (flag_n),
        .flag_z    (flag_z),
        .flag_v    (flag_v),
        .op_cnt    (op_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {c,n,z,v,result} from unsigned/signed integer arithmetic.
    function automatic logic [11:0] model(input logic [2:0] o, input logic [7:0] xa, input logic [7:0] xb);
        int ua = int'(xa);
        int ub = int'(xb);
        int sa = int'($signed(xa));
        int sb = int'($signed(xb));
        int s;
        int sv;
        logic [7:0] r;
        logic c = 1'b0;
        logic v = 1'b0;
        case (o)
            OP_NOTA: r = ~xa;
            OP_NOTB: r = ~xb;
            OP_AND:  r = xa & xb;
            OP_OR:   r = xa | xb;
            OP_XOR:  r = xa ^ xb;
            OP_XNOR: r = ~(xa ^ xb);
            OP_ADD: begin
                s  = ua + ub;
                r  = s[7:0];
                c  = (s > 255);
                sv = sa + sb;
                v  = (sv > 127) || (sv < -128);
            end
            default: begin
                s  = ua - ub;
                r  = s[7:0];
                c  = (ua >= ub);
                sv = sa - sb;
                v  = (sv > 127) || (sv < -128);
            end
        endcase
        return {c, r[7], (r == 8'h00), v, r};
    endfunction

    task automatic fire(input string tag, input logic [2:0] o, input logic [7:0] xa, input logic [7:0] xb,
                        input logic s, input logic cl, input logic [11:0] exp);
        in_valid  = 1'b1;
        op        = o;
        a         = xa;
        b         = xb;
        src_acc   = s;
        acc_clr   = cl;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_cnt++;
        check({tag, "/out_valid"}, out_valid, 1);
        check({tag, "/result"}, result, exp[7:0]);
        check({tag, "/flags_cnzv"}, {flag_c, flag_n, flag_z, flag_v}, exp[11:8]);
        check({tag, "/op_cnt"}, op_cnt, exp_cnt % CNT_MOD);
        src_acc = 1'b0;
        acc_clr = 1'b0;
    endtask

    initial begin
        logic [2:0]  ro;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic [11:0] e;
        logic [7:0]  acc_m;

        reset     = 1'b1;
        in_valid  = 1'b1;
        a         = 8'h5A;
        b         = 8'h33;
        op        = OP_ADD;
        src_acc   = 1'b0;
        acc_clr   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset/out_valid", out_valid, 0);
        check("reset/result", result, 0);
        check("reset/op_cnt", op_cnt, 0);
        check("reset/flags", {flag_c, flag_n, flag_z, flag_v}, 0);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("reset/in_ready", in_ready, 1);

        foreach (dir[i])
            fire("directed", dir[i].o, dir[i].xa, dir[i].xb, 1'b0, 1'b0, {dir[i].cnzv, dir[i].res});

        // Backpressure: result held, in_ready low, no accepts while sink stalls.
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("drain/out_valid", out_valid, 0);
        in_valid  = 1'b1;
        op        = OP_ADD;
        a         = 8'h11;
        b         = 8'h22;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        exp_cnt++;
        check("bp/first", result, 8'h33);
        op = OP_SUB;
        a  = 8'h44;
        b  = 8'h05;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp/in_ready", in_ready, 0);
            @(posedge clk);
            #1;
            check("bp/result_hold", result, 8'h33);
            check("bp/valid_hold", out_valid, 1);
            check("bp/op_cnt_hold", op_cnt, exp_cnt % CNT_MOD);
        end
        out_ready = 1'b1;
        #1;
        check("bp/release_ready", in_ready, 1);
        @(posedge clk);
        #1;
        exp_cnt++;
        check("bp/release_result", result, 8'h3F);
        check("bp/release_cnt", op_cnt, exp_cnt % CNT_MOD);
        for (int i = 0; i < 4; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = 8'($urandom);
            rb = 8'($urandom);
            fire("bp/stream", ro, ra, rb, 1'b0, 1'b0, model(ro, ra, rb));
        end

        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = 8'($urandom);
            rb = 8'($urandom);
            e  = model(ro, ra, rb);
            fire("rand", ro, ra, rb, 1'b0, 1'b0, e);
            if ($urandom_range(0, 3) == 0) begin
                in_valid  = 1'b0;
                out_ready = 1'b0;
                @(posedge clk);
                #1;
                check("rand/stall_result", result, e[7:0]);
                check("rand/stall_valid", out_valid, 1);
            end
        end
        check("wrap/op_cnt", op_cnt, exp_cnt - CNT_MOD);

`ifdef ALU_SEQ_ACC_EN
        in_valid = 1'b0;
        acc_clr  = 1'b1;
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
        acc_m   = 8'h00;
        for (int i = 0; i < 4; i++) begin
            e = model(OP_ADD, acc_m, 8'h40);
            fire("acc/chain", OP_ADD, 8'($urandom), 8'h40, 1'b1, 1'b0, e);
            acc_m = e[7:0];
        end
        check("acc/chain_end", {flag_c, result}, 9'h100);
        e = model(OP_ADD, acc_m, 8'h10);
        fire("acc/pre_clr", OP_ADD, 8'hAA, 8'h10, 1'b1, 1'b0, e);
        acc_m = e[7:0];
        e = model(OP_ADD, acc_m, 8'h05);
        fire("acc/clr_fire", OP_ADD, 8'hAA, 8'h05, 1'b1, 1'b1, e);
        acc_m = 8'h00;
        fire("acc/after_clr", OP_ADD, 8'hAA, 8'h07, 1'b1, 1'b0, model(OP_ADD, acc_m, 8'h07));
        check("acc/after_clr_val", result, 8'h07);
`else
        acc_m = 8'h12;
        fire("noacc/ignored", OP_ADD, acc_m, 8'h01, 1'b1, 1'b1, model(OP_ADD, acc_m, 8'h01));
        check("noacc/val", result, 8'h13);
`endif

        // Reset while a stalled result is pending discards it.
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset/out_valid", out_valid, 0);
        check("midreset/result", result, 0);
        check("midreset/op_cnt", op_cnt, 0);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("midreset/in_ready", in_ready, 1);

        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the 4-bit gate-level ALU datapath. It performs one of eight logic or arithmetic operations on WIDTH-bit operands and returns the result with carry, negative, zero and overflow flags through a one-stage valid/ready pipeline register. An optional accumulator feeds the previous result back as operand A. The block sits between the operand/opcode source (register file or testbench driver) and the result sink.

## Interface
- WIDTH, 8: operand and result width, must be ≥ 2
- CNT_W, 16: width of the completed-operation counter

- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand/opcode present
- in_ready  out  1  block can accept this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  3  opcode
- src_acc  in  1  use accumulator instead of `a` (only with ALU_SEQ_ACC_EN)
- acc_clr  in  1  clear accumulator (only with ALU_SEQ_ACC_EN)
- out_valid  out  1  result register holds an unconsumed result
- out_ready  in  1  sink accepts the result
- result  out  WIDTH  registered result
- flag_c, flag_n, flag_z, flag_v  out  1 each  registered carry, negative, zero and overflow flags
- op_cnt  out  CNT_W  number of accepted operations, wraps modulo 2^CNT_W

## Operation
- Opcodes:
  - 000: NOT A
  - 001: NOT B
  - 010: A AND B
  - 011: A OR B
  - 100: A XOR B
  - 101: A XNOR B
  - 110: A+B
  - 111: A−B, computed as A + ~B + 1
- Arithmetic is done at WIDTH+1 bits, and result is the low WIDTH bits.
  - flag_c is bit WIDTH of the sum. For SUB, flag_c=1 means no borrow.
  - flag_v is 1 when both operand MSBs (B inverted for SUB) are equal and differ from result MSB.
- Logic ops force flag_c=0 and flag_v=0.
- flag_n = result[WIDTH−1]; flag_z = (result == 0). Both apply to all ops.
- An input transaction fires when in_valid && in_ready. An output transaction fires when out_valid && out_ready.
- in_ready = !out_valid || out_ready, which gives full throughput when the sink is always ready.
- On input fire, result, flags and out_valid←1 load. On output fire without input fire, out_valid←0.
- While out_valid && !out_ready: result and flags hold stable and in_ready=0.
- op_cnt increments on every input fire.

## Timing
- Latency: one cycle from input fire to out_valid=1 with result.
- Reset values: out_valid=0, result=0, all flags=0, op_cnt=0, accumulator=0. in_ready=1 in the cycle after reset.
- Reset mid-operation discards any pending result. The next cycle shows out_valid=0.
- When input and output fire in the same cycle, the new result replaces the old one and out_valid stays 1.
- in_valid while in_ready=0: the inputs are ignored. The source must hold them until the transaction fires.
- op_cnt wraps from 2^CNT_W−1 to 0 with no flag.

## Configuration
- ALU_SEQ_ACC_EN defined:
  - A WIDTH-bit accumulator loads result on every input fire.
  - With src_acc=1, operand A is the accumulator value before this cycle's update, so back-to-back accumulation works at full rate.
  - acc_clr sets the accumulator to 0 on the next edge. It wins over a simultaneous input fire, whose output still uses the old accumulator.
- ALU_SEQ_ACC_EN undefined:
  - No accumulator register exists.
  - src_acc and acc_clr are ignored and operand A is always `a`.

## Structure
- Package alu_seq_pkg holds:
  - opcode localparams OP_NOTA … OP_SUB
  - the 3-bit opcode width
- Sub-module alu_core: purely combinational. Takes A, B and op; produces the next result and the four flags.
- The top level holds the pipeline register, handshake, accumulator and counter.

## Test plan
All cases use WIDTH=8.
- Reset with in_valid=1 → out_valid=0, result=0x00, op_cnt=0 while reset is asserted.
- ADD a=0x7F, b=0x01 → result=0x80, v=1, n=1, c=0, z=0. ADD 0xFF+0x01 → 0x00, c=1, z=1, v=0.
- SUB 0x05−0x05 → 0x00, c=1, z=1. SUB 0x00−0x01 → 0xFF, c=0, n=1. SUB 0x80−0x01 → 0x7F, v=1.
- Logic: a=0xF0, b=0x3C → AND 0x30, OR 0xFC, XOR 0xCC, XNOR 0x33, NOT A 0x0F, NOT B 0xC3. c=v=0 for every one.
- Backpressure:
  - Hold out_ready=0 for 3 cycles after a result → result stable, in_ready=0, op_cnt unchanged.
  - Release with in_valid held → one new accept per cycle.
- ACC_EN: acc_clr, then four ADDs with src_acc=1 and b=0x40 → results 0x40, 0x80, 0xC0, 0x00 (c=1). acc_clr together with an input fire → that output uses the old accumulator, and the next src_acc op sees 0.
